// File: rtl/stage1_fifo_writer_pkg.sv
// Shared widths and the lookup-result entry type for the stage-1 FIFO writer.
package stage1_fifo_writer_pkg;

  localparam int BBLOCK_W = 32;
  localparam int NHOP_W   = 32;
  localparam int FIFO_W   = 64;

  typedef struct packed {
    logic [BBLOCK_W-1:0] bblock;
    logic [NHOP_W-1:0]   nhop;
  } entry_t;

  function automatic logic [FIFO_W-1:0] entry_to_word(input entry_t e);
    return {e.bblock, e.nhop};
  endfunction

endpackage

// File: rtl/stage1_skid_buf.sv
// Small circular FIFO holding RAM lookup results until the downstream FIFO takes them.
module stage1_skid_buf
  import stage1_fifo_writer_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                         core_sp_clk,
  input  logic                         reset,
  input  logic                         push,
  input  entry_t                       push_data,
  input  logic                         pop,
  output entry_t                       head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge core_sp_clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge core_sp_clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/stage1_fifo_writer.sv
// Issues lookup RAM reads under a credit scheme and forwards the results, in order, to the next stage's FIFO.
module stage1_fifo_writer
  import stage1_fifo_writer_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int BUF_DEPTH = 3
) (
  input  logic                core_sp_clk,
  input  logic                reset,
  input  logic                req_valid,
  input  logic [ADDR_W-1:0]   req_addr,
  output logic                req_ready,
  output logic                ram_rd_en,
  output logic [ADDR_W-1:0]   ram_addr,
  input  logic [BBLOCK_W-1:0] ram_bblock,
  input  logic [NHOP_W-1:0]   ram_nhop,
  input  logic                fifo_full,
  output logic                fifo_write,
  output logic [FIFO_W-1:0]   fifo_wdata,
  output logic [31:0]         wr_count
);

  localparam int CNT_W = $clog2(BUF_DEPTH+1);

  logic [CNT_W-1:0]  buf_count;
  entry_t            push_data;
  entry_t            head_data;
  logic              accept;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]       wr_count_q, wr_count_d;

  // A read in flight already owns a buffer slot, so it counts against the credit.
  always_comb begin
    req_ready  = ({1'b0, buf_count} + {{CNT_W{1'b0}}, inflight_q}) < (CNT_W+1)'(BUF_DEPTH);
    accept     = req_valid & req_ready;
    fifo_write = (buf_count != '0) & ~fifo_full;
    ram_rd_en  = accept;
    ram_addr_d = accept ? req_addr : ram_addr_q;
    ram_addr   = ram_addr_d;
    inflight_d = accept;
    wr_count_d = fifo_write ? wr_count_q + 32'd1 : wr_count_q;
    push_data  = '{bblock: ram_bblock, nhop: ram_nhop};
  end

  always_ff @(posedge core_sp_clk or posedge reset) begin
    if (reset) begin
      inflight_q <= 1'b0;
      ram_addr_q <= '0;
      wr_count_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      ram_addr_q <= ram_addr_d;
      wr_count_q <= wr_count_d;
    end
  end

  stage1_skid_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .core_sp_clk (core_sp_clk),
    .reset       (reset),
    .push        (inflight_q),
    .push_data   (push_data),
    .pop         (fifo_write),
    .head_data   (head_data),
    .count       (buf_count)
  );

  assign fifo_wdata = entry_to_word(head_data);
  assign wr_count   = wr_count_q;

endmodule

// File: tb/tb_stage1_fifo_writer.sv
// Directed bench for stage1_fifo_writer: vector table for backpressure plus hand sequences.
module tb_stage1_fifo_writer;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [15:0] req_addr;
  logic        req_ready;
  logic        ram_rd_en;
  logic [15:0] ram_addr;
  logic [31:0] ram_bblock;
  logic [31:0] ram_nhop;
  logic        fifo_full;
  logic        fifo_write;
  logic [63:0] fifo_wdata;
  logic [31:0] wr_count;

  int n_tests = 0;
  int n_fail  = 0;
  int n_writes = 0;
  logic [15:0] exp_q[$];
  logic        chk_cnt = 1'b0;

  stage1_fifo_writer #(.ADDR_W(16), .BUF_DEPTH(3)) dut (
    .core_sp_clk (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_ready   (req_ready),
    .ram_rd_en   (ram_rd_en),
    .ram_addr    (ram_addr),
    .ram_bblock  (ram_bblock),
    .ram_nhop    (ram_nhop),
    .fifo_full   (fifo_full),
    .fifo_write  (fifo_write),
    .fifo_wdata  (fifo_wdata),
    .wr_count    (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] bb_of(input logic [15:0] a);
    return {16'hAAAA, a ^ 16'h0011};
  endfunction

  function automatic logic [31:0] nh_of(input logic [15:0] a);
    return {16'h0000, a} - 32'd5;
  endfunction

  // Lookup RAM: one-cycle read latency.
  initial begin
    ram_bblock = '0;
    ram_nhop   = '0;
  end
  always @(posedge clk) begin
    if (ram_rd_en) begin
      ram_bblock <= bb_of(ram_addr);
      ram_nhop   <= nh_of(ram_addr);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic observe();
    logic [15:0] a;
    if (fifo_write) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL write_unexpected: fifo_write=1, expected 0 (no pending accept) t=%0t", $time);
      end else begin
        a = exp_q.pop_front();
        chk("wdata_order", fifo_wdata, {bb_of(a), nh_of(a)});
      end
    end
    if (req_valid && req_ready) exp_q.push_back(req_addr);
    if (chk_cnt) chk("count_le3", 64'(dut.buf_count <= 2'd3), 64'd1);
  endtask

  task automatic cyc(input logic v, input logic [15:0] a, input logic ff);
    @(negedge clk);
    req_valid = v;
    req_addr  = a;
    fifo_full = ff;
    #1;
    observe();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset     = 1'b1;
    req_valid = 1'b0;
    fifo_full = 1'b0;
    #1;
    exp_q.delete();
    n_writes = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic        v;
    logic [15:0] a;
    logic        ff;
    logic        e_rdy;
    logic        e_fw;
    logic [63:0] e_wd;
  } vec_t;

  vec_t tbl[9];

  initial begin
    // Backpressure: three accepts fill the credit, release drains them in order.
    tbl[0] = '{1'b1, 16'h0100, 1'b1, 1'b1, 1'b0, 64'h0};
    tbl[1] = '{1'b1, 16'h0104, 1'b1, 1'b1, 1'b0, 64'h0};
    tbl[2] = '{1'b1, 16'h0108, 1'b1, 1'b1, 1'b0, 64'h0};
    tbl[3] = '{1'b1, 16'h010C, 1'b1, 1'b0, 1'b0, 64'h0};
    tbl[4] = '{1'b1, 16'h010C, 1'b1, 1'b0, 1'b0, 64'h0};
    tbl[5] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 64'hAAAA0111_000000FB};
    tbl[6] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 64'hAAAA0115_000000FF};
    tbl[7] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 64'hAAAA0119_00000103};
    tbl[8] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 64'h0};

    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    fifo_full = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_fifo_write", fifo_write, 0);
    chk("rst_ram_rd_en", ram_rd_en, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_wr_count", wr_count, 0);
    @(negedge clk);
    reset = 1'b0;

    // Basic single lookup.
    cyc(1'b1, 16'h0010, 1'b0);
    chk("basic_ready", req_ready, 1);
    chk("basic_rd_en", ram_rd_en, 1);
    chk("basic_addr", ram_addr, 16'h0010);
    chk("basic_fw_t0", fifo_write, 0);
    cyc(1'b0, 16'h0000, 1'b0);
    chk("basic_rd_en_t1", ram_rd_en, 0);
    chk("basic_addr_hold", ram_addr, 16'h0010);
    chk("basic_fw_t1", fifo_write, 0);
    cyc(1'b0, 16'h0000, 1'b0);
    chk("basic_fw_t2", fifo_write, 1);
    chk("basic_wdata", fifo_wdata, 64'hAAAA0001_0000000B);
    cyc(1'b0, 16'h0000, 1'b0);
    chk("basic_fw_t3", fifo_write, 0);
    chk("basic_wr_count", wr_count, 1);

    // Streaming: eight back-to-back requests.
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 16'h0200 + 16'(i * 4), 1'b0);
      chk("stream_ready", req_ready, 1);
      chk("stream_fw", fifo_write, 64'(i >= 2));
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 16'h0000, 1'b0);
      chk("stream_fw_tail", fifo_write, 1);
    end
    cyc(1'b0, 16'h0000, 1'b0);
    chk("stream_fw_done", fifo_write, 0);
    chk("stream_wr_count", wr_count, 8);
    chk("stream_n_writes", 64'(n_writes), 8);

    // Backpressure table.
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].v, tbl[i].a, tbl[i].ff);
      chk("bp_ready", req_ready, 64'(tbl[i].e_rdy));
      chk("bp_write", fifo_write, 64'(tbl[i].e_fw));
      if (tbl[i].e_fw) chk("bp_wdata", fifo_wdata, tbl[i].e_wd);
    end
    chk("bp_wr_count", wr_count, 3);

    // Simultaneous push/pop with fifo_full toggling.
    apply_reset();
    cyc(1'b1, 16'h0300, 1'b1);
    cyc(1'b0, 16'h0000, 1'b1);
    chk_cnt = 1'b1;
    for (int i = 0; i < 16; i++) cyc(1'b1, 16'h0310 + 16'(i * 4), (i % 2) == 0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 16'h0000, 1'b0);
    chk_cnt = 1'b0;
    chk("pp_drained", 64'(exp_q.size()), 0);
    chk("pp_wr_count", wr_count, 64'(n_writes));

    // Reset with two buffered entries and one read in flight.
    apply_reset();
    cyc(1'b1, 16'h0400, 1'b1);
    cyc(1'b1, 16'h0404, 1'b1);
    cyc(1'b1, 16'h0408, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    fifo_full = 1'b0;
    reset     = 1'b1;
    #1;
    chk("mid_rst_fw", fifo_write, 0);
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_rd_en", ram_rd_en, 0);
    chk("mid_rst_addr", ram_addr, 0);
    chk("mid_rst_wr_count", wr_count, 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 16'h0000, 1'b0);
      chk("post_rst_fw", fifo_write, 0);
      chk("post_rst_ready", req_ready, 1);
    end
    chk("post_rst_wr_count", wr_count, 0);

    // wr_count wrap.
    apply_reset();
    @(negedge clk);
    force dut.wr_count_q = 32'hFFFF_FFFE;
    cyc(1'b0, 16'h0000, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0);
    release dut.wr_count_q;
    cyc(1'b0, 16'h0000, 1'b0);
    chk("wrap_preload", wr_count, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'h0500 + 16'(i * 4), 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 16'h0000, 1'b0);
    chk("wrap_wr_count", wr_count, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
